// File: rtl/pulse_gen_pkg.sv
// Shared state encoding and default widths for the programmable pulse generator.
package pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_gen_cnt.sv
// Loadable down-counter used to time the HIGH and LOW phases of each pulse.
module pulse_gen_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= CNT_W'(r_count - 1'b1);
    end
  end

  // Zero marks the last cycle of the current phase.
  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse source: burst or continuous pulses of latched width/period.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pout,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);

  state_e           r_state;
  logic             r_pout;
  logic             r_busy;
  logic             r_done;
  logic [NUM_W-1:0] r_pulse_cnt;
  logic             r_cont;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_width;
  logic [NUM_W-1:0] r_num;

  logic             w_start_ok;
  logic             w_valid;
  logic [CNT_W-1:0] w_width_eff;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_en;
  logic             w_zero;
  logic             w_more;

  assign w_start_ok  = start && !stop;
  assign w_valid     = (period >= CNT_W'(2)) && (width != '0) &&
                       (cont || (num_pulses != '0));
  // Guarantee at least one low cycle per period.
  assign w_width_eff = (width >= period) ? CNT_W'(period - 1'b1) : width;
  assign w_more      = r_cont || (r_pulse_cnt < r_num);

  // Phase counter control: load on phase entry, count down within a phase.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok && w_valid) begin
          w_load     = 1'b1;
          w_load_val = CNT_W'(w_width_eff - 1'b1);
        end
      end
      ST_HIGH: begin
        if (!stop) begin
          if (w_zero) begin
            w_load     = 1'b1;
            w_load_val = CNT_W'(r_period - r_width - 1'b1);
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (!stop) begin
          if (w_zero) begin
            w_load     = 1'b1;
            w_load_val = CNT_W'(r_width - 1'b1);
          end else begin
            w_en = 1'b1;
          end
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  pulse_gen_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero_c   (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pout      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse_cnt <= '0;
      r_cont      <= 1'b0;
      r_period    <= '0;
      r_width     <= '0;
      r_num       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_start_ok) begin
            r_cont      <= cont;
            r_period    <= period;
            r_width     <= w_width_eff;
            r_num       <= num_pulses;
            r_pulse_cnt <= '0;
            if (w_valid) begin
              r_state <= ST_HIGH;
              r_pout  <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (stop) begin
            r_state <= ST_FIN;
            r_pout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_zero) begin
            r_state     <= ST_LOW;
            r_pout      <= 1'b0;
            r_pulse_cnt <= NUM_W'(r_pulse_cnt + 1'b1);
          end
        end
        ST_LOW: begin
          if (stop) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_zero) begin
            if (w_more) begin
              r_state <= ST_HIGH;
              r_pout  <= 1'b1;
            end else begin
              r_state <= ST_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_pout  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pout      = r_pout;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen; cycle k is observed 1 time unit after edge k-1.
module tb_pulse_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cont;
  logic [15:0] period;
  logic [15:0] width;
  logic [7:0]  num_pulses;
  logic        pout;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_cnt;

  int total = 0;
  int bad   = 0;

  pulse_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .period     (period),
    .width      (width),
    .num_pulses (num_pulses),
    .pout       (pout),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_out(input int cyc, input logic ep, input logic eb, input logic ed);
    chk("pout", cyc, 32'(pout), 32'(ep));
    chk("busy", cyc, 32'(busy), 32'(eb));
    chk("done", cyc, 32'(done), 32'(ed));
  endtask

  task automatic cfg(input logic c, input int p, input int w, input int n);
    cont       = c;
    period     = 16'(p);
    width      = 16'(w);
    num_pulses = 8'(n);
  endtask

  // Pulse start for one edge; afterwards the bench sits in cycle 1.
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg(1'b0, 0, 0, 0);
    tick(); tick();
    chk_out(0, 1'b0, 1'b0, 1'b0);
    chk("rst_cnt", 0, 32'(pulse_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Burst: period 4, width 1, three pulses.
    cfg(1'b0, 4, 1, 3);
    go();
    for (int c = 1; c <= 14; c++) begin
      chk_out(c, (c == 1 || c == 5 || c == 9), (c >= 1 && c <= 12), (c == 13));
      if (c == 14) chk("burst_cnt", c, 32'(pulse_cnt), 32'd3);
      tick();
    end

    // Clamp: width 5 on period 3 becomes width 2.
    cfg(1'b0, 3, 5, 1);
    go();
    for (int c = 1; c <= 5; c++) begin
      chk_out(c, (c <= 2), (c <= 3), (c == 4));
      if (c == 5) chk("clamp_cnt", c, 32'(pulse_cnt), 32'd1);
      tick();
    end

    // Stop during continuous LOW phase.
    cfg(1'b1, 10, 4, 0);
    go();
    for (int c = 1; c <= 8; c++) begin
      chk_out(c, (c <= 4), (c <= 6), (c == 7));
      if (c == 6 || c == 8) chk("stop_cnt", c, 32'(pulse_cnt), 32'd1);
      stop = (c == 6);
      tick();
    end
    stop = 1'b0;

    // Invalid configs go straight to FIN.
    cfg(1'b0, 1, 1, 1);
    go();
    for (int c = 1; c <= 3; c++) begin
      chk_out(c, 1'b0, 1'b0, (c == 1));
      tick();
    end
    cfg(1'b0, 4, 1, 0);
    go();
    for (int c = 1; c <= 3; c++) begin
      chk_out(c, 1'b0, 1'b0, (c == 1));
      if (c == 1) chk("inv_cnt", c, 32'(pulse_cnt), 32'd0);
      tick();
    end
    cfg(1'b1, 4, 0, 0);
    go();
    chk_out(1, 1'b0, 1'b0, 1'b1);
    tick(); tick();

    // Stop and start together in IDLE: nothing happens.
    cfg(1'b0, 4, 1, 3);
    stop = 1'b1;
    go();
    stop = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk_out(c, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Start while busy (HIGH and FIN) and config changes are ignored.
    cfg(1'b0, 4, 2, 2);
    go();
    for (int c = 1; c <= 10; c++) begin
      chk_out(c, (c == 1 || c == 2 || c == 5 || c == 6), (c <= 8), (c == 9));
      if (c == 2) cfg(1'b1, 7, 1, 9);
      start = (c == 2 || c == 9);
      tick();
    end
    start = 1'b0;
    chk("busy_cnt", 11, 32'(pulse_cnt), 32'd2);

    // Continuous wrap: period 2, width 1; count is c/2 at even cycle c, mod 256.
    cfg(1'b1, 2, 1, 0);
    go();
    for (int c = 1; c < 514; c++) begin
      if (c == 2) chk("wrap_c2", c, 32'(pulse_cnt), 32'd1);
      if (c == 512) chk("wrap_c512", c, 32'(pulse_cnt), 32'd0);
      tick();
    end
    chk("wrap_c514", 514, 32'(pulse_cnt), 32'd1);
    chk("wrap_pout", 514, 32'(pout), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out(515, 1'b0, 1'b0, 1'b1);
    tick();

    // Synchronous reset in the middle of a burst.
    cfg(1'b0, 4, 1, 3);
    go();
    for (int c = 1; c < 6; c++) tick();
    chk("pre_rst_cnt", 6, 32'(pulse_cnt), 32'd2);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out(7 + c, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_cnt", 7 + c, 32'(pulse_cnt), 32'd0);
    end
    rst_n = 1'b1;
    tick(); tick();
    chk_out(11, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
